pcie_ats_inv_requester: RTL
===========================

# pcie_ats_inv_requester

Issues PCIe ATS Invalidate Request messages on the RQ AXI-stream and tracks each outstanding request by ITag until its Invalidation Completion messages come back on the CQ stream. It is the translation-agent end of the invalidation handshake, placed beside the CQ path.
- It snoops CQ beats passively: it never drives or stalls the CQ stream.
- It reports per-ITag retirement as done or timed-out pulses to the invalidation scheduler.

## Interface
- AXIS_DATA_WIDTH, 512, RQ/CQ data width (≥256).
- CQ_TUSER_W, 229, CQ tuser width.
- RQ_TUSER_W, 183, RQ tuser width.
- NUM_ITAGS, 32, tracked ITags (1..32).
- TIMEOUT_CYCLES, 24'd1000000, per-ITag completion timeout.
- INV_REQ_CODE, 8'h01, Invalidate Request message code.
- INV_CPL_CODE, 8'h02, Invalidation Completion message code.
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  invalidation command offered.
- cmd_ready  out  1  command accepted on `cmd_valid && cmd_ready`.
- cmd_addr  in  64  untranslated address; bits [63:12] used.
- cmd_size  in  1  S bit (range encoded in address).
- cmd_global  in  1  global invalidate bit.
- cmd_dev_id  in  16  destination function ID.
- rq_axis_tdata / tkeep / tvalid / tlast / tuser  out  AXIS_DATA_WIDTH / /8 / 1 / 1 / RQ_TUSER_W  request stream.
- rq_axis_tready  in  1  RQ backpressure.
- cq_axis_tdata / tvalid / tready / tuser  in  AXIS_DATA_WIDTH / 1 / 1 / CQ_TUSER_W  snooped CQ beats.
- itag_busy  out  NUM_ITAGS  ITag outstanding.
- done_vec  out  NUM_ITAGS  one-cycle pulse: ITag retired normally.
- timeout_vec  out  NUM_ITAGS  one-cycle pulse: ITag retired by timeout.
- stray_cpl  out  1  one-cycle pulse: completion matched no busy ITag.

## Operation
**FSM states: IDLE, SEND.**
- `cmd_ready = (state==IDLE) && |~itag_busy`.
- On accept, allocate the lowest-index free ITag, build the beat, set its busy bit, and go to SEND.
- SEND holds `rq_axis_tvalid` and the beat stable until `rq_axis_tready`, then returns to IDLE.

**RQ beat, single beat, tlast=1.**
- tkeep = 64'h0000_0000_00FF_FFFF (16-byte descriptor + 8-byte payload).
- Descriptor:
  - [47:0]=0
  - [63:48]=cmd_dev_id
  - [74:64]=11'd2
  - [78:75]=4'b1110
  - [79]=0
  - [95:80]=0
  - [103:96]={3'b0,itag}
  - [111:104]=INV_REQ_CODE
  - [114:112]=3'b010 (ID routed)
  - [127:115]=0
- Payload:
  - [191:140]=cmd_addr[63:12]
  - [139]=cmd_size
  - [138:129]=0
  - [128]=cmd_global
- tuser:
  - [15:0]=0
  - [21:20]=2'b01
  - [23:22]=0
  - [27:26]=2'b01
  - [31:28]=4'd5
  - [36]=0
  - all other bits 0
- Unused tdata bits are 0.

**CQ completion match.** A beat matches when all of these hold:
- `cq_axis_tvalid && cq_axis_tready`
- `cq_axis_tuser[81:80]!=0`
- `tdata[78:75]==4'b1110`
- `tdata[111:104]==INV_CPL_CODE`

From a matching beat:
- ITag vector = tdata[31:0].
- CC = tdata[34:32]; CC=0 means 8.

**Per-ITag tracking**, for each busy ITag whose vector bit is set:
- First completion: latch `remaining = CC-1`.
- Later completions: decrement `remaining`.
- Retire when remaining reaches 0: clear busy, pulse done_vec.
- Vector bits set for non-busy ITags, or for ITags ≥ NUM_ITAGS, pulse stray_cpl once per beat.

## Timing
- All outputs are registered; reset values are 0 (cmd_ready=0 during reset, 1 on the first cycle after release).
- Command accepted in cycle N:
  - rq_axis_tvalid=1 and the itag_busy bit set in N+1.
  - Next accept no earlier than the cycle after the tready handshake.
- Matching CQ beat in cycle M: busy clear and done_vec pulse in M+1. A freed ITag is allocatable in M+1.
- Multiple ITags in one vector retire in the same cycle.
- Completion and timeout in the same cycle for one ITag: completion wins, so done_vec is pulsed and timeout_vec is not.
- Reset asserted mid-SEND: tvalid drops asynchronously and all ITag state clears; no partial beat resumes.

## Configuration
**ATS_INV_TIMEOUT_EN**
- Defined:
  - Each ITag has a 24-bit counter, cleared at allocation and incremented while busy.
  - When it reaches TIMEOUT_CYCLES: clear busy, pulse timeout_vec, discard remaining count.
  - Late completions for that ITag then count as stray_cpl.
- Undefined:
  - No counters; timeout_vec tied 0.
  - ITags stay busy until completed.

## Test plan
- Single command addr=64'h0000_1234_5678_9000, dev_id=16'h0100, rq_tready=1 -> one beat with:
  - [103:96]=8'h00, [111:104]=8'h01
  - [191:140]=addr[63:12], tkeep=64'hFF_FFFF
  - itag_busy=1 for ITag 0
- CQ completion vector=32'h1, CC=1 -> done_vec[0] pulse one cycle later; itag_busy=0.
- Three commands, then one CQ beat with vector=32'h7, CC=2 -> no retire; a second identical beat -> done_vec=3'b111 in one cycle.
- rq_tready low 10 cycles -> beat held stable, cmd_ready=0 throughout.
- All 32 ITags busy -> cmd_ready=0; completing ITag 5 -> next command gets ITag 5.
- With ATS_INV_TIMEOUT_EN and TIMEOUT_CYCLES=100, no completion -> timeout_vec[0] pulses 100 cycles after allocation; a later completion for ITag 0 pulses stray_cpl.

Source files
------------

// File: rtl/pcie_ats_inv_requester.sv
// ATS Invalidate Request issuer with per-ITag completion tracking on snooped CQ beats.
// Optional per-ITag completion timeout is enabled by defining ATS_INV_TIMEOUT_EN.
module pcie_ats_inv_requester #(
  parameter int          AXIS_DATA_WIDTH = 512,
  parameter int          CQ_TUSER_W      = 229,
  parameter int          RQ_TUSER_W      = 183,
  parameter int          NUM_ITAGS       = 32,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd1000000,
  parameter logic [7:0]  INV_REQ_CODE    = 8'h01,
  parameter logic [7:0]  INV_CPL_CODE    = 8'h02
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [63:0]                  cmd_addr,
  input  logic                         cmd_size,
  input  logic                         cmd_global,
  input  logic [15:0]                  cmd_dev_id,
  output logic [AXIS_DATA_WIDTH-1:0]   rq_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] rq_axis_tkeep,
  output logic                         rq_axis_tvalid,
  output logic                         rq_axis_tlast,
  output logic [RQ_TUSER_W-1:0]        rq_axis_tuser,
  input  logic                         rq_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]   cq_axis_tdata,
  input  logic                         cq_axis_tvalid,
  input  logic                         cq_axis_tready,
  input  logic [CQ_TUSER_W-1:0]        cq_axis_tuser,
  output logic [NUM_ITAGS-1:0]         itag_busy,
  output logic [NUM_ITAGS-1:0]         done_vec,
  output logic [NUM_ITAGS-1:0]         timeout_vec,
  output logic                         stray_cpl
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam logic [KEEP_W-1:0]     RQ_KEEP = KEEP_W'(24'hFF_FFFF);
  localparam logic [RQ_TUSER_W-1:0] RQ_USER = RQ_TUSER_W'(32'h5410_0000);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic                         r_cmd_ready;
  logic                         w_cmd_ready_next;
  logic                         w_accept;
  logic [NUM_ITAGS-1:0]         r_busy;
  logic [NUM_ITAGS-1:0]         w_busy_next;
  logic [NUM_ITAGS-1:0]         r_done;
  logic [NUM_ITAGS-1:0]         w_done_next;
  logic [NUM_ITAGS-1:0]         r_timeout;
  logic [NUM_ITAGS-1:0]         w_timeout_next;
  logic                         r_stray;
  logic                         w_stray_next;
  logic [4:0]                   w_free_itag;
  logic                         w_any_free;
  logic [AXIS_DATA_WIDTH-1:0]   r_tdata;
  logic [AXIS_DATA_WIDTH-1:0]   w_tdata;
  logic [KEEP_W-1:0]            r_tkeep;
  logic                         r_tvalid;
  logic                         r_tlast;
  logic [RQ_TUSER_W-1:0]        r_tuser;
  logic                         w_cq_match;
  logic [31:0]                  w_cpl_vec;
  logic [31:0]                  w_busy32;
  logic [2:0]                   w_cc_rem;
  logic                         w_unused;

  assign w_accept = cmd_valid && r_cmd_ready;

  // Lowest-index free ITag wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_free_itag = '0;
    w_any_free  = 1'b0;
    for (int i = NUM_ITAGS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_itag = 5'(i);
        w_any_free  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SEND;
      SEND:    if (rq_axis_tready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_cmd_ready_next = (w_state_next == IDLE) && |(~w_busy_next);

  always_comb begin
    w_tdata           = '0;
    w_tdata[63:48]    = cmd_dev_id;
    w_tdata[74:64]    = 11'd2;
    w_tdata[78:75]    = 4'b1110;
    w_tdata[103:96]   = {3'b000, w_free_itag};
    w_tdata[111:104]  = INV_REQ_CODE;
    w_tdata[114:112]  = 3'b010;
    w_tdata[128]      = cmd_global;
    w_tdata[139]      = cmd_size;
    w_tdata[191:140]  = cmd_addr[63:12];
  end

  assign w_cq_match = cq_axis_tvalid && cq_axis_tready && (cq_axis_tuser[81:80] != 2'b00) &&
                      (cq_axis_tdata[78:75] == 4'b1110) && (cq_axis_tdata[111:104] == INV_CPL_CODE);
  assign w_cpl_vec  = w_cq_match ? cq_axis_tdata[31:0] : 32'd0;
  // CC of 0 encodes 8; the 3-bit wrap of CC-1 yields 7 remaining for that case.
  assign w_cc_rem   = cq_axis_tdata[34:32] - 3'd1;

  always_comb begin
    w_busy32 = '0;
    for (int i = 0; i < NUM_ITAGS; i++) w_busy32[i] = r_busy[i];
  end

  assign w_stray_next = w_cq_match && |(w_cpl_vec & ~w_busy32);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITAGS; gi++) begin : g_itag
      logic       w_alloc;
      logic       w_hit;
      logic       w_cpl_retire;
      logic       w_to_retire;
      logic       r_seen;
      logic [2:0] r_rem;

      assign w_alloc      = w_accept && (w_free_itag == 5'(gi));
      assign w_hit        = r_busy[gi] && w_cpl_vec[gi];
      assign w_cpl_retire = w_hit && (r_seen ? (r_rem == 3'd1) : (w_cc_rem == 3'd0));

`ifdef ATS_INV_TIMEOUT_EN
      logic [23:0] r_cnt;
      // A completion retiring in the same cycle takes precedence over the timeout.
      assign w_to_retire = r_busy[gi] && ((r_cnt + 24'd1) == TIMEOUT_CYCLES) && !w_cpl_retire;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (w_alloc) begin
          r_cnt <= '0;
        end else if (r_busy[gi]) begin
          r_cnt <= r_cnt + 24'd1;
        end
      end
`else
      assign w_to_retire = 1'b0;
`endif

      assign w_busy_next[gi]    = w_alloc | (r_busy[gi] & ~w_cpl_retire & ~w_to_retire);
      assign w_done_next[gi]    = w_cpl_retire;
      assign w_timeout_next[gi] = w_to_retire;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_seen <= 1'b0;
          r_rem  <= '0;
        end else if (w_alloc) begin
          r_seen <= 1'b0;
          r_rem  <= '0;
        end else if (w_hit) begin
          r_seen <= 1'b1;
          r_rem  <= r_seen ? (r_rem - 3'd1) : w_cc_rem;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= '0;
      r_done      <= '0;
      r_timeout   <= '0;
      r_stray     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tuser     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cmd_ready <= w_cmd_ready_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_timeout   <= w_timeout_next;
      r_stray     <= w_stray_next;
      r_tvalid    <= (w_state_next == SEND);
      if (w_accept) begin
        r_tdata <= w_tdata;
        r_tkeep <= RQ_KEEP;
        r_tlast <= 1'b1;
        r_tuser <= RQ_USER;
      end
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rq_axis_tdata  = r_tdata;
  assign rq_axis_tkeep  = r_tkeep;
  assign rq_axis_tvalid = r_tvalid;
  assign rq_axis_tlast  = r_tlast;
  assign rq_axis_tuser  = r_tuser;
  assign itag_busy      = r_busy;
  assign done_vec       = r_done;
  assign timeout_vec    = r_timeout;
  assign stray_cpl      = r_stray;

  assign w_unused = ^{cmd_addr[11:0], cq_axis_tdata[AXIS_DATA_WIDTH-1:112], cq_axis_tdata[74:35],
                      cq_axis_tuser[CQ_TUSER_W-1:82], cq_axis_tuser[79:0], w_any_free};

endmodule
